// File: rtl/bc_pkg.sv
// bc_pkg: shared encodings and defaults for the barcode decoder
package bc_pkg;
    localparam int PER_W_DEF   = 22;
    localparam int MIN_PER_DEF = 16;
    localparam int GAP_TMO_DEF = 4;
    localparam logic [1:0] ID_VALID_MASK = 2'b00;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MEAS      = 3'd1;
    localparam logic [2:0] WAIT_FALL = 3'd2;
    localparam logic [2:0] WAIT_SAMP = 3'd3;
    localparam logic [2:0] CHECK     = 3'd4;
endpackage

// File: rtl/bc_sync_edge.sv
// bc_sync_edge: two-flop synchroniser with a third flop for falling-edge detection
module bc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic bc_s,
    output logic fall
);
    logic [2:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= 3'b111;
        else ff <= {ff[1:0], bc};
    assign bc_s = ff[1];
    assign fall = ff[2] & ~ff[1];
endmodule

// File: rtl/barcode_decoder.sv
// barcode_decoder: self-clocked serial barcode to 8-bit station ID
module barcode_decoder
    import bc_pkg::*;
#(
    parameter int PER_W   = PER_W_DEF,
    parameter int MIN_PER = MIN_PER_DEF,
    parameter int GAP_TMO = GAP_TMO_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic       ID_vld,
    output logic [7:0] ID,
    output logic       frm_err
);
    logic             bc_s, fall;
    logic [2:0]       state;
    logic [PER_W-1:0] per_cnt, period, smp_cnt;
    logic [PER_W+1:0] gap_cnt, gap_lim;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;

    bc_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .bc(BC), .bc_s(bc_s), .fall(fall));

    // two extra bits keep GAP_TMO*period from wrapping
    assign gap_lim = (PER_W+2)'(period) * (PER_W+2)'(GAP_TMO);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            per_cnt   <= '0;
            period    <= '0;
            smp_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ID        <= '0;
            ID_vld    <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (clr_ID_vld) ID_vld <= 1'b0;
            case (state)
                IDLE:
                    if (fall) begin
                        state   <= MEAS;
                        per_cnt <= '0;
                    end
                MEAS:
                    if (bc_s) begin
                        state   <= (per_cnt >= PER_W'(MIN_PER)) ? WAIT_FALL : IDLE;
                        period  <= per_cnt;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (&per_cnt) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else per_cnt <= per_cnt + 1'b1;
                WAIT_FALL:
                    if (fall) begin
                        state   <= WAIT_SAMP;
                        smp_cnt <= '0;
                    end else if (gap_cnt >= gap_lim) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else gap_cnt <= gap_cnt + 1'b1;
                WAIT_SAMP:
                    if (smp_cnt == period) begin
                        shift_reg <= {shift_reg[6:0], bc_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                        gap_cnt   <= '0;
                        state     <= (bit_cnt == 4'd7) ? CHECK : WAIT_FALL;
                    end else smp_cnt <= smp_cnt + 1'b1;
                CHECK: begin
                    state <= IDLE;
                    // the set here overrides a simultaneous clr_ID_vld
                    if (shift_reg[7:6] == ID_VALID_MASK) begin
                        ID     <= shift_reg;
                        ID_vld <= 1'b1;
                    end else frm_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_barcode_decoder.sv
// tb_barcode_decoder: scoreboard bench for barcode_decoder
module tb_barcode_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BC = 1'b1;
    logic       clr_ID_vld = 1'b0;
    logic       ID_vld, frm_err;
    logic [7:0] ID;

    int         n_chk = 0, n_pass = 0, n_err = 0;
    logic [7:0] sb_q[$];
    logic       prev_vld = 1'b0;
    logic [7:0] prev_id = 8'h00;

    barcode_decoder dut (
        .clk(clk), .rst_n(rst_n), .BC(BC), .clr_ID_vld(clr_ID_vld),
        .ID_vld(ID_vld), .ID(ID), .frm_err(frm_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic lvl, input int n);
        BC = lvl;
        repeat (n) @(negedge clk);
    endtask

    // each bit cell is two periods; a '1' rises before the sample point, a '0' after
    task automatic send_frame(input logic [7:0] v, input int p, input int nbits, input bit idle);
        drive(1'b0, p);
        drive(1'b1, p);
        for (int i = 7; i > 7 - nbits; i--)
            if (v[i]) begin
                drive(1'b0, p / 2);
                drive(1'b1, 3 * p / 2);
            end else begin
                drive(1'b0, 3 * p / 2);
                drive(1'b1, p / 2);
            end
        if (idle) drive(1'b1, 2 * p);
    endtask

    task automatic good_frame(input logic [7:0] v, input int p);
        sb_q.push_back(v);
        send_frame(v, p, 8, 1'b1);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            prev_id  = 8'h00;
        end else begin
            if (frm_err) n_err++;
            if (ID_vld && (!prev_vld || ID != prev_id)) begin
                if (sb_q.size() == 0) chk("sb_extra", ID, 8'hxx);
                else chk("sb_id", ID, sb_q.pop_front());
            end
            prev_vld = ID_vld;
            prev_id  = ID;
        end
    end

    initial begin
        int e0;
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_id", ID, 8'h00);
        chk("rst_vld", ID_vld, 1'b0);
        chk("rst_err", frm_err, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 10);

        good_frame(8'h2A, 1000);
        chk("2a_vld", ID_vld, 1'b1);
        chk("2a_no_err", n_err, 0);

        good_frame(8'h15, 200);
        e0 = n_err;
        send_frame(8'hC5, 200, 8, 1'b1);
        chk("c5_err", n_err, e0 + 1);
        chk("c5_id", ID, 8'h15);
        chk("c5_vld", ID_vld, 1'b1);

        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        chk("clr_vld0", ID_vld, 1'b0);

        sb_q.push_back(8'h3F);
        hit = 1'b0;
        fork
            send_frame(8'h3F, 200, 8, 1'b1);
            for (int i = 0; i < 30000 && !hit; i++) begin
                @(negedge clk);
                if (dut.state == bc_pkg::CHECK) begin
                    hit = 1'b1;
                    clr_ID_vld = 1'b1;
                    @(negedge clk);
                    clr_ID_vld = 1'b0;
                    chk("3f_set_wins", ID_vld, 1'b1);
                end
            end
        join
        chk("3f_check_seen", hit, 1'b1);
        chk("3f_drain", sb_q.size(), 0);
        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        chk("3f_clr", ID_vld, 1'b0);

        e0 = n_err;
        drive(1'b0, 8);
        drive(1'b1, 50);
        chk("glitch_err", n_err, e0);
        chk("glitch_vld", ID_vld, 1'b0);
        good_frame(8'h01, 200);

        e0 = n_err;
        send_frame(8'hA0, 500, 3, 1'b0);
        drive(1'b1, 3000);
        chk("tmo_err", n_err, e0 + 1);
        chk("tmo_id", ID, 8'h01);
        good_frame(8'h22, 500);

        send_frame(8'h0A, 200, 4, 1'b0);
        rst_n = 1'b0;
        BC = 1'b1;
        @(negedge clk);
        chk("mid_rst_id", ID, 8'h00);
        chk("mid_rst_vld", ID_vld, 1'b0);
        @(negedge clk);
        chk("mid_rst_err", frm_err, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 400);
        good_frame(8'h11, 200);
        chk("11_vld", ID_vld, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
